// File: rtl/battleship_player_core.sv
// ---------------------------------------------------------------------------
// battleship_player_core
//
// One player's board for the Battleship game. It holds the ship layout,
// checks and registers this player's cumulative attack map, and applies
// checked opponent attacks to the surviving-ship map. It reports hit, error
// and liveness status to the game FSM and the word display.
//
// Parameters
//   CELLS       board positions, one bit per cell (2..32)
//   SHIPS       exact number of ship cells required at load (1..CELLS)
//
// Ports
//   clk          system clock
//   clr_n        asynchronous active-low reset
//   sw           switches: ship layout in SETUP, cumulative attack map in PLAY
//   load_btn     synchronised button, commits the ship layout
//   fire_btn     synchronised button, commits an attack
//   turn         high while this player may fire
//   opp_attack   opponent cumulative attack map
//   opp_valid    one-cycle strobe, opp_attack has been updated
//   attack_out   registered own cumulative attack map
//   attack_valid one-cycle strobe, attack_out just changed
//   ships_out    surviving ship cells
//   hit_pulse    one-cycle strobe, an accepted opponent attack hit a ship
//   err          one-cycle strobe, an input was rejected
//   alive        high only in PLAY
//   state        SETUP=00, PLAY=01, DEAD=10
// ---------------------------------------------------------------------------
module battleship_player_core #(
   parameter int CELLS = 8,
   parameter int SHIPS = 3
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [CELLS-1:0] sw,
   input  logic             load_btn,
   input  logic             fire_btn,
   input  logic             turn,
   input  logic [CELLS-1:0] opp_attack,
   input  logic             opp_valid,
   output logic [CELLS-1:0] attack_out,
   output logic             attack_valid,
   output logic [CELLS-1:0] ships_out,
   output logic             hit_pulse,
   output logic             err,
   output logic             alive,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_SETUP = 2'b00,
      ST_PLAY  = 2'b01,
      ST_DEAD  = 2'b10
   } state_t;

   // Six bits hold any popcount up to 32 cells.
   localparam logic [5:0] SHIPS_W = 6'(SHIPS);

   // Number of set bits in a board map.
   function automatic logic [5:0] popcount(input logic [CELLS-1:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < CELLS; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   // Registered state
   state_t           state_r;
   logic [CELLS-1:0] attack_r;
   logic [CELLS-1:0] ships_r;
   logic [CELLS-1:0] oprev_r;
   logic             load_prev_r;
   logic             fire_prev_r;
   logic             attack_valid_r;
   logic             hit_r;
   logic             err_r;
   logic             alive_r;

   // Next-state values
   state_t           state_nxt_s;
   logic [CELLS-1:0] attack_nxt_s;
   logic [CELLS-1:0] ships_nxt_s;
   logic [CELLS-1:0] oprev_nxt_s;
   logic             attack_valid_nxt_s;
   logic             hit_nxt_s;
   logic             err_nxt_s;

   // Input qualification
   logic             load_edge_s;
   logic             fire_edge_s;
   logic [CELLS-1:0] own_new_s;
   logic             own_ok_s;
   logic [CELLS-1:0] opp_new_s;
   logic             opp_ok_s;
   logic [CELLS-1:0] ships_after_s;

   assign load_edge_s = load_btn & ~load_prev_r;
   assign fire_edge_s = fire_btn & ~fire_prev_r;

   // An own attack must keep every earlier shot and add exactly one new cell.
   assign own_new_s = sw & ~attack_r;
   assign own_ok_s  = turn && ((sw & attack_r) == attack_r) &&
                      (popcount(own_new_s) == 6'd1);

   // The opponent map follows the same monotonic one-new-cell rule.
   assign opp_new_s     = opp_attack & ~oprev_r;
   assign opp_ok_s      = ((opp_attack & oprev_r) == oprev_r) &&
                          (popcount(opp_new_s) == 6'd1);
   assign ships_after_s = ships_r & ~opp_new_s;

   // Next-state and strobe decode for the game FSM.
   always_comb begin
      state_nxt_s        = state_r;
      attack_nxt_s       = attack_r;
      ships_nxt_s        = ships_r;
      oprev_nxt_s        = oprev_r;
      attack_valid_nxt_s = 1'b0;
      hit_nxt_s          = 1'b0;
      err_nxt_s          = 1'b0;

      case (state_r)
         ST_SETUP: begin
            if (load_edge_s) begin
               if (popcount(sw) == SHIPS_W) begin
                  ships_nxt_s = sw;
                  state_nxt_s = ST_PLAY;
               end else begin
                  err_nxt_s = 1'b1;
               end
            end else begin
               ships_nxt_s = ships_r;
            end
            // Firing or receiving attacks before the layout is set is an error.
            if (fire_edge_s || opp_valid) begin
               err_nxt_s = 1'b1;
            end else begin
               err_nxt_s = err_nxt_s;
            end
         end

         ST_PLAY: begin
            // Own fire and opponent attack are independent and may coincide.
            if (fire_edge_s) begin
               if (own_ok_s) begin
                  attack_nxt_s       = sw;
                  attack_valid_nxt_s = 1'b1;
               end else begin
                  err_nxt_s = 1'b1;
               end
            end else begin
               attack_nxt_s = attack_r;
            end

            if (opp_valid) begin
               if (opp_ok_s) begin
                  oprev_nxt_s = opp_attack;
                  ships_nxt_s = ships_after_s;
                  hit_nxt_s   = |(opp_new_s & ships_r);
                  if (ships_after_s == {CELLS{1'b0}}) begin
                     state_nxt_s = ST_DEAD;
                  end else begin
                     state_nxt_s = ST_PLAY;
                  end
               end else begin
                  err_nxt_s = 1'b1;
               end
            end else begin
               oprev_nxt_s = oprev_r;
            end
         end

         ST_DEAD: begin
            // Sticky until reset: everything holds, no strobes.
            state_nxt_s = ST_DEAD;
         end

         default: begin
            state_nxt_s = ST_SETUP;
         end
      endcase
   end

   // Game state, maps, button history and output strobes.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r        <= ST_SETUP;
         attack_r       <= {CELLS{1'b0}};
         ships_r        <= {CELLS{1'b0}};
         oprev_r        <= {CELLS{1'b0}};
         load_prev_r    <= 1'b0;
         fire_prev_r    <= 1'b0;
         attack_valid_r <= 1'b0;
         hit_r          <= 1'b0;
         err_r          <= 1'b0;
         alive_r        <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         attack_r       <= attack_nxt_s;
         ships_r        <= ships_nxt_s;
         oprev_r        <= oprev_nxt_s;
         load_prev_r    <= load_btn;
         fire_prev_r    <= fire_btn;
         attack_valid_r <= attack_valid_nxt_s;
         hit_r          <= hit_nxt_s;
         err_r          <= err_nxt_s;
         // Registered from the next state so alive drops with the DEAD entry.
         alive_r        <= (state_nxt_s == ST_PLAY);
      end
   end

   assign attack_out   = attack_r;
   assign attack_valid = attack_valid_r;
   assign ships_out    = ships_r;
   assign hit_pulse    = hit_r;
   assign err          = err_r;
   assign alive        = alive_r;
   assign state        = state_r;

endmodule

// File: tb/tb_battleship_player_core.sv
// ---------------------------------------------------------------------------
// Self-checking bench for battleship_player_core (CELLS=8, SHIPS=3).
// A driver applies stimulus on the falling edge, advances a rule-level model
// of the game and queues the expected outputs; a monitor pops and compares
// one entry after each rising edge.
// ---------------------------------------------------------------------------
module tb_battleship_player_core;

   localparam int CELLS = 8;
   localparam int SHIPS = 3;

   logic             clk = 1'b0;
   logic             clr_n = 1'b0;
   logic [CELLS-1:0] sw = 8'h00;
   logic             load_btn = 1'b0;
   logic             fire_btn = 1'b0;
   logic             turn = 1'b0;
   logic [CELLS-1:0] opp_attack = 8'h00;
   logic             opp_valid = 1'b0;
   logic [CELLS-1:0] attack_out;
   logic             attack_valid;
   logic [CELLS-1:0] ships_out;
   logic             hit_pulse;
   logic             err;
   logic             alive;
   logic [1:0]       state;

   battleship_player_core #(.CELLS(CELLS), .SHIPS(SHIPS)) dut (
      .clk(clk), .clr_n(clr_n), .sw(sw), .load_btn(load_btn),
      .fire_btn(fire_btn), .turn(turn), .opp_attack(opp_attack),
      .opp_valid(opp_valid), .attack_out(attack_out),
      .attack_valid(attack_valid), .ships_out(ships_out),
      .hit_pulse(hit_pulse), .err(err), .alive(alive), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] attack;
      logic [7:0] ships;
      logic       av;
      logic       hit;
      logic       err;
      logic       alive;
      logic [1:0] state;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   // Reference model: game phase 0=setup 1=play 2=dead, plus the maps.
   int         m_phase;
   logic [7:0] m_attack, m_ships, m_oprev;
   logic       m_lp, m_fp;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_attack = 8'h00; m_ships = 8'h00; m_oprev = 8'h00;
      m_lp = 1'b0; m_fp = 1'b0;
   endfunction

   // One clock of stimulus plus the matching model step.
   task automatic step(input logic [7:0] s, input logic lb, input logic fb,
                       input logic t, input logic [7:0] oa, input logic ov);
      exp_t e;
      logic load_e, fire_e;
      logic [7:0] nb;
      @(negedge clk);
      sw = s; load_btn = lb; fire_btn = fb; turn = t;
      opp_attack = oa; opp_valid = ov;
      e.av = 1'b0; e.hit = 1'b0; e.err = 1'b0;
      load_e = lb && !m_lp;
      fire_e = fb && !m_fp;
      m_lp = lb; m_fp = fb;
      if (m_phase == 0) begin
         if (load_e) begin
            if ($countones(s) == SHIPS) begin
               m_ships = s; m_phase = 1;
            end else begin
               e.err = 1'b1;
            end
         end
         if (fire_e || ov) e.err = 1'b1;
      end else if (m_phase == 1) begin
         if (fire_e) begin
            if (t && ((m_attack & ~s) == 8'h00) && ($countones(s & ~m_attack) == 1)) begin
               m_attack = s; e.av = 1'b1;
            end else begin
               e.err = 1'b1;
            end
         end
         if (ov) begin
            nb = oa & ~m_oprev;
            if (((m_oprev & ~oa) == 8'h00) && ($countones(nb) == 1)) begin
               e.hit = ((nb & m_ships) != 8'h00);
               m_ships = m_ships & ~nb;
               m_oprev = oa;
               if (m_ships == 8'h00) m_phase = 2;
            end else begin
               e.err = 1'b1;
            end
         end
      end
      e.attack = m_attack;
      e.ships  = m_ships;
      e.state  = 2'(m_phase);
      e.alive  = (m_phase == 1);
      q.push_back(e);
   endtask

   task automatic idle(input logic t);
      step(sw, 1'b0, 1'b0, t, opp_attack, 1'b0);
   endtask

   // Asynchronous reset between clock edges, checked immediately.
   task automatic do_reset();
      @(negedge clk);
      #2;
      clr_n = 1'b0;
      load_btn = 1'b0; fire_btn = 1'b0; opp_valid = 1'b0; turn = 1'b0;
      #1;
      check("rst_attack", 32'(attack_out), 32'h0);
      check("rst_ships", 32'(ships_out), 32'h0);
      check("rst_state", 32'(state), 32'h0);
      check("rst_alive", 32'(alive), 32'h0);
      check("rst_strobes", 32'({attack_valid, hit_pulse, err}), 32'h0);
      model_reset();
      @(posedge clk);
      #2;
      clr_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_bit();
      return 8'(1 << $urandom_range(0, 7));
   endfunction

   // Monitor: compare DUT outputs against the queued expectation.
   initial begin : monitor
      exp_t me;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            me = q.pop_front();
            check("attack_out", 32'(attack_out), 32'(me.attack));
            check("ships_out", 32'(ships_out), 32'(me.ships));
            check("attack_valid", 32'(attack_valid), 32'(me.av));
            check("hit_pulse", 32'(hit_pulse), 32'(me.hit));
            check("err", 32'(err), 32'(me.err));
            check("alive", 32'(alive), 32'(me.alive));
            check("state", 32'(state), 32'(me.state));
         end
      end
   end

   initial begin : driver
      logic [7:0] v, o;
      logic       lb, fb, ov;
      model_reset();
      do_reset();
      idle(1'b0);

      // Setup: bad count rejected, then a good layout.
      step(8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(1'b0);
      step(8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(1'b0);

      // Own fire: accepted, accepted, lowered bit, two new bits.
      step(8'h10, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); idle(1'b1);
      step(8'h30, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); idle(1'b1);
      step(8'h20, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); idle(1'b1);
      step(8'hF0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); idle(1'b1);
      // Not our turn, then a held button.
      step(8'h70, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); idle(1'b1);
      repeat (5) step(8'h70, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      idle(1'b1);

      // Opponent attacks on consecutive cycles: hit, miss, lowered bit.
      step(8'h70, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
      step(8'h70, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1);
      step(8'h70, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
      // Same-cycle valid fire and valid hit.
      step(8'hF0, 1'b0, 1'b1, 1'b1, 8'h83, 1'b1);
      idle(1'b1);
      // Last ship sunk, then inputs ignored while dead.
      step(8'hF0, 1'b0, 1'b0, 1'b1, 8'h87, 1'b1);
      idle(1'b1);
      step(8'hF8, 1'b1, 1'b1, 1'b1, 8'h8F, 1'b1);
      idle(1'b1);

      // Reset mid-PLAY.
      do_reset();
      step(8'h38, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(8'h01, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1);
      idle(1'b1);
      do_reset();
      idle(1'b0);

      // Randomised games.
      for (int g = 0; g < 6; g++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            lb = 1'($urandom_range(0, 1));
            fb = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 2) == 0);
            if (m_phase == 0) begin
               v = 8'h00;
               if ($urandom_range(0, 3) != 0) begin
                  while ($countones(v) < SHIPS) v = v | rand_bit();
               end else begin
                  v = 8'($urandom);
               end
            end else begin
               v = ($urandom_range(0, 4) != 0) ? (m_attack | rand_bit()) : 8'($urandom);
            end
            o = ($urandom_range(0, 4) != 0) ? (m_oprev | rand_bit()) : 8'($urandom);
            step(v, lb, fb, 1'($urandom_range(0, 1)), o, ov);
         end
      end

      @(posedge clk);
      #3;
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/battleship_player_core.md
# battleship_player_core

Parametrised per-player board core for the Battleship design, generalising the 8-cell player top to `CELLS` board positions. It holds one player's ship layout, validates and registers that player's cumulative attack map, and applies validated opponent attacks to the surviving-ship map. It reports hit, error and liveness status upward to the game FSM and the seven-segment word display. One instance sits on each board, master and slave, between the switch/button inputs and the board-to-board link.

## Interface
Parameters
- `CELLS`, 8: board positions, one bit per cell (2..32).
- `SHIPS`, 3: exact number of ship cells required at load (1..CELLS).

Ports
- `clk`  in  1  system clock.
- `clr_n`  in  1  asynchronous active-low reset.
- `sw`  in  CELLS  player switches: ship layout in SETUP, cumulative attack map in PLAY.
- `load_btn`  in  1  synchronised button; commits the ship layout.
- `fire_btn`  in  1  synchronised button; commits an attack.
- `turn`  in  1  high while this player may fire.
- `opp_attack`  in  CELLS  opponent cumulative attack map.
- `opp_valid`  in  1  one-cycle strobe; `opp_attack` is updated.
- `attack_out`  out  CELLS  registered own cumulative attack map.
- `attack_valid`  out  1  one-cycle strobe; `attack_out` just changed.
- `ships_out`  out  CELLS  surviving ship cells.
- `hit_pulse`  out  1  one-cycle strobe; a valid opponent attack hit a ship.
- `err`  out  1  one-cycle strobe; an input was rejected.
- `alive`  out  1  high only in PLAY.
- `state`  out  2  SETUP=00, PLAY=01, DEAD=10; drives display word select.

## Operation
- Rising-edge detectors on `load_btn` and `fire_btn` use one registered previous sample each. An action fires only in the cycle where btn=1 and prev=0.

SETUP
- Load edge with popcount(`sw`)==SHIPS: `ships_out`<=`sw`, go to PLAY.
- Load edge with any other popcount: `err` pulse, stay in SETUP.
- Fire edge or `opp_valid`: ignored, `err` pulse.

PLAY, own fire (on a fire edge)
- Let new = `sw` & ~`attack_out`.
- The attack is valid iff `turn`=1, (`sw` & `attack_out`)==`attack_out` (no previously fired bit lowered), and popcount(new)==1.
- Valid: `attack_out`<=`sw` and `attack_valid` pulses.
- Invalid: `err` pulse, no state change.

PLAY, opponent attack (on `opp_valid`)
- Let onew = `opp_attack` & ~oprev, where oprev is an internal CELLS-bit register, reset 0.
- Valid iff `opp_attack` is a superset of oprev and popcount(onew)==1.
- Valid: oprev<=`opp_attack`, `ships_out`<=`ships_out` & ~onew, and `hit_pulse` if (onew & `ships_out`)!=0.
- If the resulting `ships_out`==0: go to DEAD.
- Invalid: `err` pulse; oprev and `ships_out` unchanged.

Simultaneous events
- A fire edge and `opp_valid` in the same cycle are evaluated independently and both take effect.
- `err` is the OR of both rejections.

DEAD
- Sticky until `clr_n`. All inputs are ignored, no pulses are generated, and `attack_out`/`ships_out` hold.

## Timing
- Reset (async, `clr_n`=0): state=SETUP; `attack_out`, `ships_out`, oprev and edge registers = 0; all strobes = 0; `alive`=0.
- Release is synchronous to the next `clk` edge.
- Latency: a qualifying input at edge k produces registered outputs and strobes visible after edge k+1 (strobes last exactly one cycle).
- A button held high produces a single action; the next action needs a low cycle first.
- Reset asserted mid-game clears everything immediately, with no wait for `clk`.
- `opp_valid` asserted on consecutive cycles is processed on each cycle.
- `alive` falls in the same cycle that `state` becomes DEAD.

## Test plan
(CELLS=8, SHIPS=3)
- Reset, load `sw`=8'b0000_0111 -> `ships_out`=0x07, `state`=01, `alive`=1. Load with 8'b0000_0011 -> `err` pulse, `state`=00.
- PLAY, `turn`=1, fire `sw`=0x10 -> `attack_out`=0x10, `attack_valid` one cycle. Fire `sw`=0x30 -> accepted. Fire `sw`=0x20 (bit lowered) or 0xF0 (two new) -> `err`, `attack_out`=0x30.
- Fire with `turn`=0 -> `err`, no `attack_valid`. Fire held high 5 cycles -> one action only.
- Ships 0x07; `opp_attack` 0x01 -> `hit_pulse`, `ships_out`=0x06. Then 0x81 -> no hit, ships 0x06. Then 0x80 -> `err`. Then 0x83, then 0x87 -> `state`=10, `alive`=0.
- Same-cycle valid fire and valid hit -> `attack_valid` and `hit_pulse` both assert, both registers update.
- `clr_n` low mid-PLAY, between clock edges -> all outputs 0, `state`=00 immediately.
